store_merge_rmw: RTL and testbench
==================================

Name: store_merge_rmw

Overview:
- Write-side counterpart of the SRAM load-path output shifter.
- Accepts byte, halfword and word stores at a byte address.
- Word SRAM macros have no byte write-enables, so sub-word stores run a read-modify-write: read the word, splice the shifted lane, write it back.
- Sits between the core store port and the single-port SRAM macro wrapper.

Parameters:
- ADDR_W, 8: word-address width of the SRAM; byte address is ADDR_W+2 bits.
- READ_LAT, 1: cycles from the SRAM read-issue cycle to valid sram_rdata; must be ≥1.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- req_valid, in, 1: store request valid.
- req_ready, out, 1: high only in IDLE.
- req_addr, in, ADDR_W+2: byte address.
- req_data, in, 32: store data, right-justified.
- req_conf, in, 2: store size. 00 = byte, 01 = half, 10 = word, 11 = reserved.
- resp_valid, out, 1: one-cycle completion pulse.
- resp_err, out, 1: qualifies resp_valid; request was misaligned or reserved.
- sram_en, out, 1: SRAM access enable.
- sram_we, out, 1: 1 = write, 0 = read; valid only with sram_en.
- sram_addr, out, ADDR_W: word address = addr[ADDR_W+1:2].
- sram_wdata, out, 32: write data.
- sram_rdata, in, 32: read data, valid READ_LAT cycles after the read cycle.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - req_ready = 1; resp_valid, resp_err, sram_en, sram_we = 0; sram_addr, sram_wdata = 0.
  - Effective immediately, including mid-operation; an in-flight store is abandoned with no write.
- Accept: on req_valid & req_ready at cycle T0, register addr, data and conf; leave IDLE.
- All outputs are driven from registered state/datapath; there is no combinational path from req_* to sram_*.
- Error check at T0, first match wins:
  - conf = 11 → error.
  - half with addr[0] = 1 → error.
  - word with addr[1:0] ≠ 0 → error.
  - On error: go to ERR; at T1 resp_valid = 1, resp_err = 1, sram_en = 0 throughout; back to IDLE at T2.
- Word store, aligned: go to WRITE. At T1: sram_en = 1, we = 1, wdata = req_data, resp_valid = 1. IDLE at T2.
- Sub-word store: READ → WAIT → WRITE.
  - READ, T1: sram_en = 1, we = 0, sram_addr = word address.
  - WAIT, READ_LAT cycles: a down-counter loads READ_LAT-1 and decrements; sram_en = 0. Merge register captures sram_rdata in the cycle the counter is 0, i.e. T1+READ_LAT.
  - WRITE, T2+READ_LAT: sram_en = 1, we = 1, same sram_addr, wdata = merged word, resp_valid = 1.
  - IDLE the next cycle.
- Merge rules:
  - Byte, offset k = addr[1:0]: bits [8k+7:8k] = req_data[7:0]; other bits from rdata.
  - Half, offset addr[1] = h: bits [16h+15:16h] = req_data[15:0]; other bits from rdata.
  - Upper unused req_data bits are ignored.
- req_ready is low in every state except IDLE.
  - A new request is accepted no earlier than the cycle after resp_valid.
  - Back-to-back requests therefore cost one IDLE cycle between them.
- resp_err is 0 whenever resp_valid is 0.
- req_valid held while busy is ignored; it is not queued.
- Latency from accept to resp_valid:
  - Aligned word or error: 1 cycle.
  - Sub-word: READ_LAT + 2 cycles (3 at default).
- Illegal state encodings recover to IDLE.

Test Plan:
- Byte store: SRAM word 1 = 0xF1F2F3F4, store byte 0xAA (req_data = 0x123456AA) at addr 0x07.
  - Required: read at T1 (addr 1), write at T3 of 0xAAF2F3F4, resp_valid at T3, resp_err = 0.
- Byte sweep: same word, byte 0x00 at addrs 0x04, 0x05, 0x06.
  - Required: 0xF1F2F300, then 0xF1F200F4, then 0xF100F3F4 (memory reset to 0xF1F2F3F4 between stores).
- Halfword stores: 0xBEEF at 0x06 → 0xBEEFF3F4; at 0x04 → 0xF1F2BEEF.
  - Rerun both with READ_LAT = 3: capture at T4, write and resp at T5.
- Aligned word: 0x12345678 at 0x04.
  - Required: single write at T1 with no read, resp_valid at T1, req_ready back high at T2.
- Error cases: half at 0x05, word at 0x06, conf = 11 at 0x04.
  - Required: resp_valid = 1 and resp_err = 1 at T1, sram_en never asserted, memory unchanged.
- Reset and back-to-back:
  - Assert rst_n = 0 during WAIT of a byte store: sram_en drops asynchronously, no write occurs, req_ready = 1, memory unchanged.
  - After release, two back-to-back requests complete in order with one IDLE cycle between them.

Source files
------------

// File: rtl/store_merge_rmw.sv
// Store path in front of a single-port word SRAM that has no byte write-enables.
// Aligned word stores write directly. Byte and halfword stores read the word, merge the new lane in, and write it back.
module store_merge_rmw #(
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_conf,
  output logic              resp_valid,
  output logic              resp_err,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic [2:0]        dbg_state
);

  // Request handshake: a request is taken when req_valid && req_ready at a rising edge.
  // req_ready is high only in IDLE, and a request held while busy is dropped.
  // resp_valid pulses for exactly one cycle per accepted request. resp_err is meaningful only with it.

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  waddr_q;
  logic [1:0]         off_q;
  logic               half_q;
  logic [31:0]        wdata_q;
  logic               accept;
  logic               req_bad;
  logic [31:0]        merged;

  assign accept = req_valid && (state_q == S_IDLE);

  // Error checks are listed in priority order. Every one of them leads to ERR.
  always_comb begin
    req_bad = 1'b0;
    if (req_conf == 2'b11)                            req_bad = 1'b1;
    else if (req_conf == 2'b01 && req_addr[0])        req_bad = 1'b1;
    else if (req_conf == 2'b10 && req_addr[1:0] != 0) req_bad = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (!accept)                 state_d = S_IDLE;
        else if (req_bad)            state_d = S_ERR;
        else if (req_conf == 2'b10)  state_d = S_WRITE;
        else                         state_d = S_READ;
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  state_d = (cnt_q == '0) ? S_WRITE : S_WAIT;
      S_WRITE: state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The store data sits right-justified in wdata_q until the read word arrives.
  always_comb begin
    merged = sram_rdata;
    if (half_q) begin
      if (off_q[1]) merged[31:16] = wdata_q[15:0];
      else          merged[15:0]  = wdata_q[15:0];
    end else begin
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      waddr_q <= '0;
      off_q   <= '0;
      half_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      if (accept) begin
        waddr_q <= req_addr[ADDR_W+1:2];
        off_q   <= req_addr[1:0];
        half_q  <= req_conf[0];
        wdata_q <= req_data;
      end
      if (state_q == S_READ) begin
        cnt_q <= CNT_W'(READ_LAT - 1);
      end else if (state_q == S_WAIT) begin
        if (cnt_q == '0) wdata_q <= merged;
        else             cnt_q   <= cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    sram_en    = (state_q == S_READ) || (state_q == S_WRITE);
    sram_we    = (state_q == S_WRITE);
    resp_valid = (state_q == S_WRITE) || (state_q == S_ERR);
    resp_err   = (state_q == S_ERR);
    sram_addr  = waddr_q;
    sram_wdata = wdata_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_store_merge_rmw.sv
// Directed bench for store_merge_rmw. It drives two instances (READ_LAT 1 and 3).
// Each instance has its own behavioural SRAM with matching read latency.
module tb_store_merge_rmw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid1 = 1'b0, req_valid3 = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_conf = '0;

  logic        ready1, rv1, re1, en1, we1;
  logic [7:0]  addr1;
  logic [31:0] wdata1, rdata1;
  logic [2:0]  st1;
  logic        ready3, rv3, re3, en3, we3;
  logic [7:0]  addr3;
  logic [31:0] wdata3, rdata3;
  logic [2:0]  st3;

  int n_cmp = 0;
  int n_bad = 0;
  bit cur_sel = 1'b0;

  always #5 clk = ~clk;

  store_merge_rmw #(.ADDR_W(8), .READ_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(ready1),
    .req_addr(req_addr), .req_data(req_data), .req_conf(req_conf),
    .resp_valid(rv1), .resp_err(re1), .sram_en(en1), .sram_we(we1),
    .sram_addr(addr1), .sram_wdata(wdata1), .sram_rdata(rdata1), .dbg_state(st1)
  );

  store_merge_rmw #(.ADDR_W(8), .READ_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(ready3),
    .req_addr(req_addr), .req_data(req_data), .req_conf(req_conf),
    .resp_valid(rv3), .resp_err(re3), .sram_en(en3), .sram_we(we3),
    .sram_addr(addr3), .sram_wdata(wdata3), .sram_rdata(rdata3), .dbg_state(st3)
  );

  // Outputs of whichever instance is currently under test.
  logic        o_ready, o_rv, o_re, o_en, o_we;
  logic [7:0]  o_addr;
  logic [31:0] o_wdata;
  assign o_ready = cur_sel ? ready3 : ready1;
  assign o_rv    = cur_sel ? rv3    : rv1;
  assign o_re    = cur_sel ? re3    : re1;
  assign o_en    = cur_sel ? en3    : en1;
  assign o_we    = cur_sel ? we3    : we1;
  assign o_addr  = cur_sel ? addr3  : addr1;
  assign o_wdata = cur_sel ? wdata3 : wdata1;

  // Behavioural SRAMs. Read data is garbage except in the cycle where it is valid.
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] p3_0, p3_1, p3_2;
  int          wc1 = 0, wc3 = 0;
  logic        poke_en = 1'b0, poke_sel = 1'b0;
  logic [7:0]  poke_addr = '0;
  logic [31:0] poke_data = '0;

  always @(posedge clk) begin
    if (poke_en && !poke_sel) mem1[poke_addr] <= poke_data;
    else if (en1 && we1) begin mem1[addr1] <= wdata1; wc1 <= wc1 + 1; end
    rdata1 <= (en1 && !we1) ? mem1[addr1] : 32'hDEAD_0001;
  end

  always @(posedge clk) begin
    if (poke_en && poke_sel) mem3[poke_addr] <= poke_data;
    else if (en3 && we3) begin mem3[addr3] <= wdata3; wc3 <= wc3 + 1; end
    p3_0 <= (en3 && !we3) ? mem3[addr3] : 32'hDEAD_0003;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign rdata3 = p3_2;

  function automatic logic [31:0] mem_rd(input bit sel, input logic [7:0] a);
    return sel ? mem3[a] : mem1[a];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input bit sel, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_sel = sel; poke_addr = a; poke_data = d;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  // exp_rd / exp_wr give the cycle after acceptance in which the read / write is issued. Zero means the access must not happen.
  task automatic run_store(input string tag, input bit sel, input logic [9:0] a,
                           input logic [31:0] d, input logic [1:0] c, input int exp_lat,
                           input bit exp_err, input int exp_rd, input int exp_wr,
                           input logic [31:0] exp_mem);
    int lat = 0, rd_cyc = 0, wr_cyc = 0, n_rd = 0, n_wr = 0;
    logic err = 1'b0;
    logic [31:0] wd = '0;
    logic [7:0] wa;
    wa = a[9:2];
    cur_sel = sel;
    set_word(sel, wa, 32'hF1F2F3F4);
    @(negedge clk);
    req_addr = a; req_data = d; req_conf = c;
    if (sel) req_valid3 = 1'b1; else req_valid1 = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 20 && lat == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin req_valid1 = 1'b0; req_valid3 = 1'b0; end
      if (o_en) begin
        check_eq({tag, "_addr"}, 32'(o_addr), 32'(wa));
        if (o_we) begin n_wr++; wr_cyc = cyc; wd = o_wdata; end
        else begin n_rd++; rd_cyc = cyc; end
      end
      if (o_rv) begin lat = cyc; err = o_re; end
      else check_eq({tag, "_err_quiet"}, 32'(o_re), 32'd0);
    end
    @(negedge clk);
    check_eq({tag, "_ready"}, 32'(o_ready), 32'd1);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
    check_eq({tag, "_nrd"}, 32'(n_rd), (exp_rd != 0) ? 32'd1 : 32'd0);
    check_eq({tag, "_rdcyc"}, 32'(rd_cyc), 32'(exp_rd));
    check_eq({tag, "_nwr"}, 32'(n_wr), (exp_wr != 0) ? 32'd1 : 32'd0);
    check_eq({tag, "_wrcyc"}, 32'(wr_cyc), 32'(exp_wr));
    if (exp_wr != 0) check_eq({tag, "_wdata"}, wd, exp_mem);
    check_eq({tag, "_mem"}, mem_rd(sel, wa), exp_mem);
  endtask

  initial begin
    int wc_before;
    int resp_cyc [2];
    int nresp;
    int nwr;
    logic rdy2;
    logic [31:0] wdat [2];

    // Reset state, sampled while rst_n is still low.
    #3;
    check_eq("rst_ready", 32'(ready1), 32'd1);
    check_eq("rst_en", 32'(en1), 32'd0);
    check_eq("rst_we", 32'(we1), 32'd0);
    check_eq("rst_resp", 32'(rv1), 32'd0);
    check_eq("rst_err", 32'(re1), 32'd0);
    check_eq("rst_addr", 32'(addr1), 32'd0);
    check_eq("rst_wdata", wdata1, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Byte stores with READ_LAT=1.
    run_store("byte07", 0, 10'h007, 32'h123456AA, 2'b00, 3, 0, 1, 3, 32'hAAF2F3F4);
    run_store("byte04", 0, 10'h004, 32'h00000000, 2'b00, 3, 0, 1, 3, 32'hF1F2F300);
    run_store("byte05", 0, 10'h005, 32'hFFFFFF00, 2'b00, 3, 0, 1, 3, 32'hF1F200F4);
    run_store("byte06", 0, 10'h006, 32'h00000000, 2'b00, 3, 0, 1, 3, 32'hF100F3F4);
    // Halfword stores with READ_LAT=1 and READ_LAT=3. The upper data bits must be ignored.
    run_store("half06", 0, 10'h006, 32'hCAFEBEEF, 2'b01, 3, 0, 1, 3, 32'hBEEFF3F4);
    run_store("half04", 0, 10'h004, 32'h0000BEEF, 2'b01, 3, 0, 1, 3, 32'hF1F2BEEF);
    run_store("half06_rl3", 1, 10'h006, 32'h0000BEEF, 2'b01, 5, 0, 1, 5, 32'hBEEFF3F4);
    run_store("half04_rl3", 1, 10'h004, 32'hCAFEBEEF, 2'b01, 5, 0, 1, 5, 32'hF1F2BEEF);
    run_store("byte07_rl3", 1, 10'h007, 32'h123456AA, 2'b00, 5, 0, 1, 5, 32'hAAF2F3F4);
    // Aligned word store, then the error cases.
    run_store("word04", 0, 10'h004, 32'h12345678, 2'b10, 1, 0, 0, 1, 32'h12345678);
    run_store("err_half05", 0, 10'h005, 32'h0000BEEF, 2'b01, 1, 1, 0, 0, 32'hF1F2F3F4);
    run_store("err_word06", 0, 10'h006, 32'h12345678, 2'b10, 1, 1, 0, 0, 32'hF1F2F3F4);
    run_store("err_conf11", 0, 10'h004, 32'h12345678, 2'b11, 1, 1, 0, 0, 32'hF1F2F3F4);

    // Reset asserted during WAIT of a byte store on the READ_LAT=3 instance.
    cur_sel = 1'b1;
    set_word(1, 8'd2, 32'hF1F2F3F4);
    @(negedge clk);
    req_addr = 10'h009; req_data = 32'h00000077; req_conf = 2'b00; req_valid3 = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid3 = 1'b0;
    @(negedge clk);
    check_eq("rstw_state_wait", 32'(st3), 32'd2);
    wc_before = wc3;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstw_ready", 32'(ready3), 32'd1);
    check_eq("rstw_en", 32'(en3), 32'd0);
    check_eq("rstw_state", 32'(st3), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("rstw_nowrite", 32'(wc3 - wc_before), 32'd0);
    check_eq("rstw_mem", mem3[2], 32'hF1F2F3F4);

    // Back-to-back: the second request is held valid while the first is in flight.
    cur_sel = 1'b0;
    set_word(0, 8'd2, 32'hF1F2F3F4);
    set_word(0, 8'd3, 32'hF1F2F3F4);
    nresp = 0; nwr = 0; rdy2 = 1'b0;
    resp_cyc[0] = 0; resp_cyc[1] = 0; wdat[0] = '0; wdat[1] = '0;
    @(negedge clk);
    req_addr = 10'h008; req_data = 32'h11111111; req_conf = 2'b10; req_valid1 = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin req_addr = 10'h00E; req_data = 32'h00000055; req_conf = 2'b00; end
      if (cyc == 3) req_valid1 = 1'b0;
      if (cyc == 2) rdy2 = ready1;
      if (en1 && we1 && nwr < 2) begin wdat[nwr] = wdata1; nwr++; end
      if (rv1 && nresp < 2) begin resp_cyc[nresp] = cyc; nresp++; end
    end
    check_eq("b2b_resp0", 32'(resp_cyc[0]), 32'd1);
    check_eq("b2b_idle_ready", 32'(rdy2), 32'd1);
    check_eq("b2b_resp1", 32'(resp_cyc[1]), 32'd5);
    check_eq("b2b_nresp", 32'(nresp), 32'd2);
    check_eq("b2b_wdata0", wdat[0], 32'h11111111);
    check_eq("b2b_wdata1", wdat[1], 32'hF155F3F4);
    check_eq("b2b_mem2", mem1[2], 32'h11111111);
    check_eq("b2b_mem3", mem1[3], 32'hF155F3F4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
